// File: rtl/router_port_rx_if.sv
// Host-side byte stream of one router output-port receiver.
// The master drives the head-of-FIFO byte; the slave answers with ready.
interface router_port_rx_if;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_last, output m_valid, input m_ready);
  modport slave  (input m_data, input m_last, input m_valid, output m_ready);
endinterface

// File: rtl/router_port_rx.sv
// Output-port receiver: packs the serial router stream LSB-first into bytes,
// buffers {last, byte} entries in a FIFO and hands them to a host over a
// valid/ready stream. Counts completed packets, flags truncation and overflow.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for frameo_n_i=0; bits outside a frame are ignored
// RECV  | inside a frame, shifting bits into the current byte
// DROP  | a byte was lost to a full FIFO; discard until frame end
module router_port_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dout_i,
  input  logic             valido_n_i,
  input  logic             frameo_n_i,
  router_port_rx_if.master m_if,
  output logic [CNT_W-1:0] pkt_count,
  output logic             err_trunc,
  output logic             err_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trunc_q, trunc_d;
  logic             ovf_q, ovf_d;

  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;

  logic             fifo_full, pop, push_req, push_ok, push_last;
  logic [7:0]       byte_w, push_byte;
  logic [8:0]       head;

  assign fifo_full = (level_q == FULL_LVL);
  assign pop       = (level_q != '0) && m_if.m_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok   = push_req && (!fifo_full || pop);

  // Next-state, bit packing and push decision for the receive FSM.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    ovf_d     = ovf_q;
    push_req  = 1'b0;
    push_last = 1'b0;
    push_byte = '0;
    byte_w    = shift_q;
    byte_w[bit_cnt_q] = dout_i;

    case (state_q)
      S_IDLE: begin
        if (!frameo_n_i) begin
          state_d = S_RECV;
          if (!valido_n_i) begin
            shift_d   = byte_w;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_RECV: begin
        if (!valido_n_i) begin
          if (bit_cnt_q == 3'd7 || frameo_n_i) begin
            push_req  = 1'b1;
            push_last = frameo_n_i;
            push_byte = byte_w;
            if (frameo_n_i && bit_cnt_q != 3'd7) trunc_d = 1'b1;
          end else begin
            shift_d   = byte_w;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (frameo_n_i) begin
          // Frame closed during a pause: flush any partial byte.
          trunc_d = 1'b1;
          if (bit_cnt_q != 3'd0) begin
            push_req  = 1'b1;
            push_last = 1'b1;
            push_byte = shift_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (frameo_n_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every push starts a fresh byte; shift is cleared so partial bytes are zero-padded.
    if (push_req) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      if (!push_ok) begin
        ovf_d   = 1'b1;
        state_d = push_last ? S_IDLE : S_DROP;
      end else if (push_last) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
    end
  end

  // FSM, packing and status registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset because the output is gated by level.
  always_ff @(posedge clock) begin
    if (reset_n && push_ok) mem_q[wr_ptr_q] <= {push_last, push_byte};
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign m_if.m_valid   = (level_q != '0);
  assign m_if.m_data    = m_if.m_valid ? head[7:0] : 8'h00;
  assign m_if.m_last    = m_if.m_valid & head[8];
  assign pkt_count      = cnt_q;
  assign err_trunc      = trunc_q;
  assign err_ovf        = ovf_q;

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: per-cycle comparison against a queue-based
// packet model, frame-level vector table, directed corner sequences and
// a randomized soak.
module tb_router_port_rx;
  localparam int DEPTH = 16;

  logic        clk, rst_n, dout, vn, fn;
  logic [15:0] pkt_count;
  logic        err_trunc, err_ovf;

  router_port_rx_if bus();

  router_port_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .dout_i     (dout),
    .valido_n_i (vn),
    .frameo_n_i (fn),
    .m_if       (bus),
    .pkt_count  (pkt_count),
    .err_trunc  (err_trunc),
    .err_ovf    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: packet bits in a queue, FIFO as a queue of {last, byte}.
  bit          cur[$];
  logic [8:0]  mq[$];
  int          mode;       // 0 outside frame, 1 in frame, 2 discarding
  logic [15:0] m_cnt;
  logic        m_trunc, m_ovf;

  logic [8:0]  got[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack_bits();
    logic [7:0] v = '0;
    foreach (cur[i]) v[i] = cur[i];
    return v;
  endfunction

  task automatic model_step(input logic d, input logic v_n, input logic f_n,
                            input logic rdy, input logic rstn);
    logic       pop, push, plast;
    logic [7:0] b;
    if (!rstn) begin
      cur.delete(); mq.delete(); mode = 0;
      m_cnt = '0; m_trunc = 1'b0; m_ovf = 1'b0;
      return;
    end
    pop = (mq.size() > 0) && rdy;
    push = 1'b0; plast = 1'b0;
    case (mode)
      0: if (!f_n) begin
           mode = 1;
           if (!v_n) cur.push_back(d);
         end
      1: if (!v_n) begin
           cur.push_back(d);
           if (cur.size() == 8 || f_n) begin
             if (f_n && cur.size() < 8) m_trunc = 1'b1;
             push = 1'b1; plast = f_n;
           end
         end else if (f_n) begin
           m_trunc = 1'b1;
           if (cur.size() > 0) begin push = 1'b1; plast = 1'b1; end
           else mode = 0;
         end
      default: if (f_n) mode = 0;
    endcase
    if (push) begin
      b = pack_bits();
      cur.delete();
      if (mq.size() == DEPTH && !pop) begin
        m_ovf = 1'b1;
        mode = plast ? 0 : 2;
      end else begin
        mq.push_back({plast, b});
        if (plast) begin m_cnt++; mode = 0; end
      end
    end
    if (pop) void'(mq.pop_front());
  endtask

  task automatic cycle(input logic d, input logic v_n, input logic f_n,
                       input logic rdy, input logic rstn);
    logic [27:0] exp;
    dout = d; vn = v_n; fn = f_n; bus.m_ready = rdy; rst_n = rstn;
    if (rstn && bus.m_valid && rdy) got.push_back({bus.m_last, bus.m_data});
    model_step(d, v_n, f_n, rdy, rstn);
    @(posedge clk); #1;
    if (mq.size() > 0) exp = {1'b1, mq[0][8], mq[0][7:0], m_cnt, m_trunc, m_ovf};
    else               exp = {1'b0, 1'b0, 8'h00, m_cnt, m_trunc, m_ovf};
    check("cycle", 64'({bus.m_valid, bus.m_last, bus.m_data, pkt_count, err_trunc, err_ovf}),
          64'(exp));
  endtask

  task automatic do_reset(input int n);
    repeat (n) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    got.delete();
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cycle(1'b0, 1'b1, 1'b1, rdy, 1'b1);
  endtask

  task automatic send_frame(input int nbits, input logic [31:0] val,
                            input int pause_at, input int pause_len, input logic rdy);
    for (int i = 0; i < nbits; i++) begin
      cycle(val[i], 1'b0, (i == nbits - 1), rdy, 1'b1);
      if (i == pause_at)
        repeat (pause_len) cycle(1'b0, 1'b1, 1'b0, rdy, 1'b1);
    end
  endtask

  typedef struct {
    int          nbits;
    logic [31:0] val;
    int          pause_at;
    int          pause_len;
    int          nexp;
    logic [8:0]  e0;
    logic [8:0]  e1;
    logic        etrunc;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[5];
  logic [191:0] big;
  int rdy_pct;

  initial begin
    tbl[0] = '{16, 32'h0000C3A5, -1, 0, 2, {1'b0, 8'hA5}, {1'b1, 8'hC3}, 1'b0, 16'd1};
    tbl[1] = '{16, 32'h0000C3A5,  3, 3, 2, {1'b0, 8'hA5}, {1'b1, 8'hC3}, 1'b0, 16'd1};
    tbl[2] = '{11, 32'h000005FF, -1, 0, 2, {1'b0, 8'hFF}, {1'b1, 8'h05}, 1'b1, 16'd1};
    tbl[3] = '{ 8, 32'h0000005A, -1, 0, 1, {1'b1, 8'h5A}, 9'h000,        1'b0, 16'd1};
    tbl[4] = '{ 4, 32'h00000009,  1, 2, 1, {1'b1, 8'h09}, 9'h000,        1'b1, 16'd1};

    big = '0;
    for (int k = 0; k < 24; k++) big[k*8 +: 8] = 8'(k * 29 + 7);

    dout = 1'b0; vn = 1'b1; fn = 1'b1; rst_n = 1'b0; bus.m_ready = 1'b0;
    @(posedge clk); #1;

    // Reset state.
    do_reset(2);
    check("reset_state", 64'({bus.m_valid, bus.m_data, bus.m_last, pkt_count, err_trunc, err_ovf}), 64'h0);

    // Frame-level vector table.
    for (int t = 0; t < 5; t++) begin
      do_reset(1);
      send_frame(tbl[t].nbits, tbl[t].val, tbl[t].pause_at, tbl[t].pause_len, 1'b1);
      idle(4, 1'b1);
      check($sformatf("tbl%0d_nbytes", t), 64'(got.size()), 64'(tbl[t].nexp));
      if (got.size() > 0) check($sformatf("tbl%0d_byte0", t), 64'(got[0]), 64'(tbl[t].e0));
      if (tbl[t].nexp > 1 && got.size() > 1)
        check($sformatf("tbl%0d_byte1", t), 64'(got[1]), 64'(tbl[t].e1));
      check($sformatf("tbl%0d_count", t), 64'(pkt_count), 64'(tbl[t].ecnt));
      check($sformatf("tbl%0d_trunc", t), 64'(err_trunc), 64'(tbl[t].etrunc));
      check($sformatf("tbl%0d_ovf", t), 64'(err_ovf), 64'h0);
    end

    // m_valid appears exactly one cycle after the 8th bit's edge.
    do_reset(1);
    big[15:0] = 16'hC3A5;
    for (int i = 0; i < 8; i++) begin
      cycle(big[i], 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 6) check("lat_before", 64'(bus.m_valid), 64'h0);
    end
    check("lat_valid", 64'({bus.m_valid, bus.m_last, bus.m_data}), 64'({1'b1, 1'b0, 8'hA5}));
    for (int k = 0; k < 24; k++) big[k*8 +: 8] = 8'(k * 29 + 7);
    idle(2, 1'b1);

    // Overflow: 17 bytes with no consumer, frame continues, DROP until frame end.
    do_reset(1);
    for (int i = 0; i < 141; i++) cycle(big[i], 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("ovf_flag", 64'(err_ovf), 64'h1);
    check("ovf_count", 64'(pkt_count), 64'h0);
    idle(20, 1'b1);
    check("ovf_drained", 64'(got.size()), 64'd16);
    for (int k = 0; k < 16 && k < got.size(); k++)
      check($sformatf("ovf_byte%0d", k), 64'(got[k]), 64'({1'b0, big[k*8 +: 8]}));
    got.delete();
    send_frame(8, 32'h5A, -1, 0, 1'b1);
    idle(4, 1'b1);
    check("after_ovf_frame", 64'({got.size() == 1, got.size() > 0 ? got[0] : 9'h0}),
          64'({1'b1, 1'b1, 8'h5A}));
    check("after_ovf_count", 64'(pkt_count), 64'd1);

    // Full FIFO with a same-cycle pop: no overflow.
    do_reset(1);
    for (int i = 0; i < 136; i++) cycle(big[i], 1'b0, (i == 135), (i == 135), 1'b1);
    check("full_pop_ovf", 64'(err_ovf), 64'h0);
    check("full_pop_count", 64'(pkt_count), 64'd1);
    idle(20, 1'b1);
    check("full_pop_n", 64'(got.size()), 64'd17);
    if (got.size() == 17) begin
      check("full_pop_first", 64'(got[0]), 64'({1'b0, big[7:0]}));
      check("full_pop_last", 64'(got[16]), 64'({1'b1, big[135:128]}));
    end

    // Reset in the middle of a frame.
    do_reset(1);
    send_frame(4, 32'h9, -1, 0, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("midrst_state", 64'({bus.m_valid, pkt_count, err_trunc, err_ovf}), 64'h0);
    got.delete();
    send_frame(8, 32'h3C, -1, 0, 1'b1);
    idle(4, 1'b1);
    check("midrst_frame", 64'({got.size() == 1, got.size() > 0 ? got[0] : 9'h0}),
          64'({1'b1, 1'b1, 8'h3C}));
    check("midrst_count", 64'(pkt_count), 64'd1);

    // Randomized soak against the model.
    do_reset(1);
    rdy_pct = 50;
    for (int i = 0; i < 5000; i++) begin
      if (i % 500 == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 8;
          1:       rdy_pct = 50;
          default: rdy_pct = 95;
        endcase
      end
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 23) == 0),
            ($urandom_range(0, 99) < rdy_pct),
            !(i > 0 && $urandom_range(0, 999) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
